// File: rtl/spine_tile_switch.sv
// Spine-side tile switch: per-spine ingress FIFOs with round-robin egress to the NI,
// NI ingress unicast/broadcast to spines, overflow flags and a saturating drop counter.
module spine_tile_switch #(
  parameter int unsigned NUM_SPINES = 4,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BCAST_EN   = 1
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [NUM_SPINES-1:0]        spine_in_valid,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  output logic [DWIDTH-1:0]            local_out_data,
  output logic                         local_out_valid,
  input  logic                         local_out_ready,
  input  logic [DWIDTH-1:0]            local_in_data,
  input  logic                         local_in_valid,
  output logic                         local_in_ready,
  output logic [NUM_SPINES-1:0]        fifo_full,
  output logic [NUM_SPINES-1:0]        ovf_sticky,
  input  logic                         ovf_clr,
  output logic [7:0]                   drop_cnt
);

  localparam int unsigned SEL_W = (NUM_SPINES > 1) ? $clog2(NUM_SPINES) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned INC_W = $clog2(NUM_SPINES + 2);
  localparam int unsigned SUM_W = 10;

  logic [DWIDTH-1:0]            mem_q [NUM_SPINES][FIFO_DEPTH];
  logic [DWIDTH-1:0]            mem_d [NUM_SPINES][FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q [NUM_SPINES];
  logic [PTR_W-1:0]             wr_ptr_d [NUM_SPINES];
  logic [PTR_W-1:0]             rd_ptr_q [NUM_SPINES];
  logic [PTR_W-1:0]             rd_ptr_d [NUM_SPINES];
  logic [CNT_W-1:0]             count_q  [NUM_SPINES];
  logic [CNT_W-1:0]             count_d  [NUM_SPINES];
  logic [NUM_SPINES-1:0]        full_q, full_d;
  logic [NUM_SPINES-1:0]        sticky_q, sticky_d;
  logic [SEL_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [DWIDTH-1:0]            out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic [NUM_SPINES*DWIDTH-1:0] sp_data_q, sp_data_d;
  logic [NUM_SPINES-1:0]        sp_valid_q, sp_valid_d;
  logic                         in_ready_q, in_ready_d;
  logic [7:0]                   drop_cnt_q, drop_cnt_d;

  logic [NUM_SPINES-1:0]        req, pop, drop, push_ok;
  logic [2*NUM_SPINES-1:0]      req_rot;
  logic                         found, load_en;
  int unsigned                  win_off, win_idx;
  logic [ADDR_W-1:0]            dest;
  logic [SEL_W-1:0]             sel;
  logic                         xfer, bcast, sel_ok, bad_sel;
  logic [INC_W-1:0]             inc;
  logic [SUM_W-1:0]             sum;

  // Round-robin winner search starting at rr_ptr, plus egress register load
  always_comb begin
    for (int s = 0; s < NUM_SPINES; s++) req[s] = (count_q[s] != '0);
    req_rot = {req, req} >> rr_ptr_q;
    found   = 1'b0;
    win_off = 0;
    for (int i = 0; i < NUM_SPINES; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        win_off = i;
      end
    end
    win_idx     = (32'(rr_ptr_q) + win_off) % NUM_SPINES;
    load_en     = !out_valid_q || local_out_ready;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    pop         = '0;
    if (load_en) begin
      out_valid_d = found;
      if (found) begin
        out_data_d = mem_q[SEL_W'(win_idx)][rd_ptr_q[SEL_W'(win_idx)]];
        rr_ptr_d   = SEL_W'((win_idx + 1) % NUM_SPINES);
        for (int s = 0; s < NUM_SPINES; s++) pop[s] = (win_idx == s);
      end
    end
  end

  // Ingress FIFOs: a push into a full FIFO survives only if that FIFO pops this cycle
  always_comb begin
    mem_d = mem_q;
    for (int s = 0; s < NUM_SPINES; s++) begin
      drop[s]     = spine_in_valid[s] && (count_q[s] == CNT_W'(FIFO_DEPTH)) && !pop[s];
      push_ok[s]  = spine_in_valid[s] && !drop[s];
      wr_ptr_d[s] = push_ok[s] ? wr_ptr_q[s] + PTR_W'(1) : wr_ptr_q[s];
      rd_ptr_d[s] = pop[s] ? rd_ptr_q[s] + PTR_W'(1) : rd_ptr_q[s];
      count_d[s]  = count_q[s] + CNT_W'(push_ok[s]) - CNT_W'(pop[s]);
      full_d[s]   = (count_d[s] == CNT_W'(FIFO_DEPTH));
      if (push_ok[s]) mem_d[s][wr_ptr_q[s]] = spine_in_data[s*DWIDTH +: DWIDTH];
    end
  end

  // NI ingress: unicast by low destination bits, broadcast on all-ones
  always_comb begin
    xfer       = local_in_valid && in_ready_q;
    dest       = local_in_data[DWIDTH-1 -: ADDR_W];
    sel        = dest[SEL_W-1:0];
    bcast      = (BCAST_EN != 0) && (dest == '1);
    sel_ok     = ({1'b0, sel} < (SEL_W+1)'(NUM_SPINES));
    bad_sel    = xfer && !bcast && !sel_ok;
    in_ready_d = 1'b1;
    sp_valid_d = '0;
    sp_data_d  = sp_data_q;
    if (xfer) begin
      for (int s = 0; s < NUM_SPINES; s++) begin
        if (bcast || (sel_ok && (SEL_W'(s) == sel))) begin
          sp_valid_d[s]                 = 1'b1;
          sp_data_d[s*DWIDTH +: DWIDTH] = local_in_data;
        end
      end
    end
  end

  // Overflow flags and saturating drop counter; clear wins over new drops
  always_comb begin
    inc = INC_W'(bad_sel);
    for (int s = 0; s < NUM_SPINES; s++) inc = inc + INC_W'(drop[s]);
    sum = SUM_W'(drop_cnt_q) + SUM_W'(inc);
    if (ovf_clr) begin
      drop_cnt_d = '0;
      sticky_d   = '0;
    end else begin
      drop_cnt_d = (sum > SUM_W'(255)) ? 8'hFF : sum[7:0];
      sticky_d   = sticky_q | drop;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      count_q     <= '{default: '0};
      full_q      <= '0;
      sticky_q    <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sp_data_q   <= '0;
      sp_valid_q  <= '0;
      in_ready_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      sticky_q    <= sticky_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sp_data_q   <= sp_data_d;
      sp_valid_q  <= sp_valid_d;
      in_ready_q  <= in_ready_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign spine_out_data  = sp_data_q;
  assign spine_out_valid = sp_valid_q;
  assign local_out_data  = out_data_q;
  assign local_out_valid = out_valid_q;
  assign local_in_ready  = in_ready_q;
  assign fifo_full       = full_q;
  assign ovf_sticky      = sticky_q;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_spine_tile_switch.sv
// Scoreboard bench for spine_tile_switch: a 4-spine instance for egress/ingress traffic and
// a 3-spine instance for out-of-range select drops and counter saturation.
module tb_spine_tile_switch;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [63:0] spine_in_data;
  logic [3:0]  spine_in_valid;
  logic [63:0] spine_out_data;
  logic [3:0]  spine_out_valid;
  logic [15:0] local_out_data;
  logic        local_out_valid;
  logic        local_out_ready;
  logic [15:0] local_in_data;
  logic        local_in_valid;
  logic        local_in_ready;
  logic [3:0]  fifo_full;
  logic [3:0]  ovf_sticky;
  logic        ovf_clr;
  logic [7:0]  drop_cnt;

  logic [47:0] s3_in_data;
  logic [2:0]  s3_in_valid;
  logic [47:0] s3_out_data;
  logic [2:0]  s3_out_valid;
  logic [15:0] l3_out_data;
  logic        l3_out_valid;
  logic [15:0] l3_in_data;
  logic        l3_in_valid;
  logic        l3_in_ready;
  logic [2:0]  f3_full;
  logic [2:0]  ovf3_sticky;
  logic        ovf3_clr;
  logic [7:0]  drop3_cnt;

  spine_tile_switch u_dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .spine_in_data(spine_in_data), .spine_in_valid(spine_in_valid),
    .spine_out_data(spine_out_data), .spine_out_valid(spine_out_valid),
    .local_out_data(local_out_data), .local_out_valid(local_out_valid),
    .local_out_ready(local_out_ready),
    .local_in_data(local_in_data), .local_in_valid(local_in_valid),
    .local_in_ready(local_in_ready),
    .fifo_full(fifo_full), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
    .drop_cnt(drop_cnt)
  );

  spine_tile_switch #(.NUM_SPINES(3)) u_dut3 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .spine_in_data(s3_in_data), .spine_in_valid(s3_in_valid),
    .spine_out_data(s3_out_data), .spine_out_valid(s3_out_valid),
    .local_out_data(l3_out_data), .local_out_valid(l3_out_valid),
    .local_out_ready(1'b1),
    .local_in_data(l3_in_data), .local_in_valid(l3_in_valid),
    .local_in_ready(l3_in_ready),
    .fifo_full(f3_full), .ovf_sticky(ovf3_sticky), .ovf_clr(ovf3_clr),
    .drop_cnt(drop3_cnt)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] data;
  } sp_exp_t;

  logic [15:0] exp_q[$];
  sp_exp_t     sp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] mon_e;
  sp_exp_t     mon_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops expected flits whenever the DUT presents an accepted output
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (local_out_valid && local_out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL local_out_unexpected: got %0h expected none", local_out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("local_out_data", 64'(local_out_data), 64'(mon_e));
        end
      end
      if (spine_out_valid != 4'b0) begin
        if (sp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spine_out_unexpected: got %0h expected none", spine_out_valid);
        end else begin
          mon_s = sp_q.pop_front();
          chk("spine_out_mask", 64'(spine_out_valid), 64'(mon_s.mask));
          for (int s = 0; s < 4; s++)
            if (spine_out_valid[s]) chk("spine_out_data", 64'(spine_out_data[s*16 +: 16]), 64'(mon_s.data));
        end
      end
    end
  end

  initial begin
    spine_in_data = '0; spine_in_valid = '0; local_out_ready = 1'b1;
    local_in_data = '0; local_in_valid = 1'b0; ovf_clr = 1'b0;
    s3_in_data = '0; s3_in_valid = '0; l3_in_data = '0; l3_in_valid = 1'b0; ovf3_clr = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(local_out_valid), 64'd0);
    chk("rst_in_ready", 64'(local_in_ready), 64'd0);
    chk("rst_spine_valid", 64'(spine_out_valid), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    chk("rel_in_ready_pre", 64'(local_in_ready), 64'd0);
    tick();
    chk("rel_in_ready_post", 64'(local_in_ready), 64'd1);

    // Round-robin from pointer 0
    for (int s = 0; s < 4; s++) spine_in_data[s*16 +: 16] = 16'h1000 + 16'(s);
    spine_in_valid = 4'hF;
    exp_q.push_back(16'h1000); exp_q.push_back(16'h1001);
    exp_q.push_back(16'h1002); exp_q.push_back(16'h1003);
    tick();
    spine_in_valid = 4'h0;
    wait_drain("rr_round1_drain", 10);
    tick();
    chk("rr_idle_valid", 64'(local_out_valid), 64'd0);

    // Spine 1 alone moves the pointer to 2; next full round starts at 2
    spine_in_data[16 +: 16] = 16'h2001;
    spine_in_valid = 4'b0010;
    exp_q.push_back(16'h2001);
    tick();
    spine_in_valid = 4'h0;
    wait_drain("rr_single_drain", 10);
    for (int s = 0; s < 4; s++) spine_in_data[s*16 +: 16] = 16'h3000 + 16'(s);
    spine_in_valid = 4'hF;
    exp_q.push_back(16'h3002); exp_q.push_back(16'h3003);
    exp_q.push_back(16'h3000); exp_q.push_back(16'h3001);
    tick();
    spine_in_valid = 4'h0;
    wait_drain("rr_round2_drain", 10);
    tick();

    // Latency: valid one edge after the push edge, single beat
    spine_in_data[32 +: 16] = 16'hA5C3;
    spine_in_valid = 4'b0100;
    exp_q.push_back(16'hA5C3);
    tick();
    spine_in_valid = 4'h0;
    chk("lat_push_edge_valid", 64'(local_out_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(local_out_valid), 64'd1);
    chk("lat_data", 64'(local_out_data), 64'hA5C3);
    tick();
    chk("lat_single_beat", 64'(local_out_valid), 64'd0);

    // Backpressure and overflow on spine 0
    local_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      spine_in_data[0 +: 16] = 16'h0100 + 16'(i);
      spine_in_valid = 4'b0001;
      if (i < 5) exp_q.push_back(16'h0100 + 16'(i));
      tick();
    end
    spine_in_valid = 4'h0;
    chk("ovf_fifo_full", 64'(fifo_full), 64'h1);
    chk("ovf_sticky", 64'(ovf_sticky), 64'h1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("ovf_hold_data", 64'(local_out_data), 64'h0100);
    tick();
    chk("ovf_hold_valid", 64'(local_out_valid), 64'd1);
    local_out_ready = 1'b1;
    wait_drain("ovf_drain", 20);
    chk("ovf_full_after_drain", 64'(fifo_full), 64'h0);
    chk("ovf_sticky_kept", 64'(ovf_sticky), 64'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_sticky", 64'(ovf_sticky), 64'h0);
    chk("clr_drop_cnt", 64'(drop_cnt), 64'd0);

    // NI ingress unicast and broadcast on the 4-spine instance
    local_in_data = 16'h0D55;
    local_in_valid = 1'b1;
    sp_q.push_back('{mask: 4'b1000, data: 16'h0D55});
    tick();
    local_in_valid = 1'b0;
    chk("uni_valid", 64'(spine_out_valid), 64'b1000);
    tick();
    chk("uni_pulse_end", 64'(spine_out_valid), 64'h0);
    local_in_data = 16'hFEAA;
    local_in_valid = 1'b1;
    sp_q.push_back('{mask: 4'b1111, data: 16'hFEAA});
    tick();
    local_in_valid = 1'b0;
    chk("bc_valid", 64'(spine_out_valid), 64'hF);
    chk("bc_data", 64'(spine_out_data), 64'hFEAA_FEAA_FEAA_FEAA);
    tick();
    chk("bc_pulse_end", 64'(spine_out_valid), 64'h0);
    chk("bc_data_hold", 64'(spine_out_data), 64'hFEAA_FEAA_FEAA_FEAA);
    chk("ingress_no_drop", 64'(drop_cnt), 64'd0);

    // 3-spine instance: select 3 out of range, broadcast and unicast still work
    l3_in_data = 16'h0D55;
    l3_in_valid = 1'b1;
    tick();
    l3_in_valid = 1'b0;
    chk("s3_bad_no_pulse", 64'(s3_out_valid), 64'h0);
    chk("s3_bad_drop", 64'(drop3_cnt), 64'd1);
    l3_in_data = 16'hFC11;
    l3_in_valid = 1'b1;
    tick();
    l3_in_valid = 1'b0;
    chk("s3_bc_valid", 64'(s3_out_valid), 64'b111);
    chk("s3_bc_no_drop", 64'(drop3_cnt), 64'd1);
    l3_in_data = 16'h0877;
    l3_in_valid = 1'b1;
    tick();
    l3_in_valid = 1'b0;
    chk("s3_uni_valid", 64'(s3_out_valid), 64'b100);
    chk("s3_uni_data", 64'(s3_out_data[32 +: 16]), 64'h0877);

    // Saturation of drop counter
    ovf3_clr = 1'b1;
    tick();
    ovf3_clr = 1'b0;
    chk("s3_clr", 64'(drop3_cnt), 64'd0);
    l3_in_data = 16'h0D55;
    l3_in_valid = 1'b1;
    repeat (100) tick();
    chk("sat_100", 64'(drop3_cnt), 64'd100);
    repeat (200) tick();
    l3_in_valid = 1'b0;
    chk("sat_255", 64'(drop3_cnt), 64'd255);

    // Reset mid-traffic: 7 drops accumulate, then everything is discarded
    local_out_ready = 1'b0;
    for (int s = 0; s < 4; s++) spine_in_data[s*16 +: 16] = 16'h4000 + 16'(s);
    spine_in_valid = 4'hF;
    repeat (6) tick();
    chk("pre_rst_drop_cnt", 64'(drop_cnt), 64'd7);
    chk("pre_rst_full", 64'(fifo_full), 64'hF);
    chk("pre_rst_out_valid", 64'(local_out_valid), 64'd1);
    #2;
    ARESETn = 1'b0;
    spine_in_valid = 4'h0;
    #1;
    chk("mid_rst_out_valid", 64'(local_out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(local_out_data), 64'd0);
    chk("mid_rst_full", 64'(fifo_full), 64'h0);
    chk("mid_rst_sticky", 64'(ovf_sticky), 64'h0);
    chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("mid_rst_in_ready", 64'(local_in_ready), 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    local_out_ready = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(local_in_ready), 64'd1);
    repeat (3) tick();
    chk("post_rst_no_flit", 64'(local_out_valid), 64'd0);

    chk("sb_local_empty", 64'(exp_q.size()), 64'd0);
    chk("sb_spine_empty", 64'(sp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
